// File: rtl/exmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exmem_pkg
//  Brief    : Shared constants and types for the EX/MEM pipeline register:
//             ALU op codes, MUL hold-counter states, control bundle and its
//             bubble value.
//  Revision : 1.0 - initial release
// ============================================================================
package exmem_pkg;

    // ALU control codes as driven by the ID-stage decoder
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b011;

    // MUL hold-counter states
    typedef enum logic [0:0] {
        PASS     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // MEM/WB control bits carried through EX/MEM
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    // A bubble must never write memory or the register file
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Hold-counter width: at least one bit even for single-cycle MUL
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_mul_hold_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mul_hold_ctr
//  Brief    : Tracks a multi-cycle MUL occupying EX. Raises busy while the
//             upstream stages must hold and commit on the cycle the product
//             may be latched into EX/MEM.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_hold_ctr
    import exmem_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mul_start_i,
    input  logic stall_i,
    input  logic flush_i,
    output logic busy_o,
    output logic commit_o,
    output logic in_wait_o
);

    localparam int CNT_W    = cnt_width(MUL_LAT);
    localparam int CNT_INIT = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam bit MULTI    = (MUL_LAT > 1);

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;

    // State and countdown register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= PASS;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // Next state: flush aborts the MUL, stall freezes the count
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        if (flush_i) begin
            w_state_d = PASS;
            w_cnt_d   = '0;
        end else if (!stall_i) begin
            case (r_state_q)
                PASS: begin
                    if (mul_start_i && MULTI) begin
                        w_state_d = MUL_WAIT;
                        w_cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
                MUL_WAIT: begin
                    if (r_cnt_q != '0) begin
                        w_cnt_d = r_cnt_q - 1'b1;
                    end else begin
                        w_state_d = PASS;
                    end
                end
                default: begin
                    w_state_d = PASS;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // The start cycle itself stalls; the last wait cycle (cnt==0) commits
    always_comb begin
        in_wait_o = (r_state_q == MUL_WAIT);
        busy_o    = (mul_start_i & MULTI) | (in_wait_o & (r_cnt_q != '0));
        commit_o  = in_wait_o & (r_cnt_q == '0);
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_pipe
//  Brief    : EX/MEM pipeline register with MUL hold control, MEM stall,
//             flush and valid bookkeeping.
//             Optional macro EXMEM_PERF_CNT_EN adds perf_stall_o, a
//             saturating count of MUL-induced stall cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_pipe
    import exmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic              Zero_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic              Zero_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              ex_stall_o
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam bit MULTI = (MUL_LAT > 1);

    logic w_is_mul, w_mul_start, w_mul_busy, w_commit, w_in_wait, w_capture;

    logic              r_valid_q,  w_valid_d;
    logic [DATA_W-1:0] r_result_q, w_result_d;
    logic [DATA_W-1:0] r_rtdata_q, w_rtdata_d;
    logic              r_zero_q,   w_zero_d;
    logic [REG_AW-1:0] r_rdaddr_q, w_rdaddr_d;
    ctrl_t             r_ctrl_q,   w_ctrl_d;

    // MUL detection and the load decision: capture on commit or on a
    // single-cycle instruction arriving in PASS, otherwise load a bubble
    always_comb begin
        w_is_mul    = (ALUCtrl_i == ALU_MUL);
        w_mul_start = valid_i & w_is_mul & ~w_in_wait;
        w_capture   = w_commit | (~w_in_wait & valid_i & ~(w_is_mul & MULTI));
        ex_stall_o  = stall_i | (~flush_i & w_mul_busy);
    end

    mul_hold_ctr #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_hold_ctr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mul_start_i (w_mul_start),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .busy_o      (w_mul_busy),
        .commit_o    (w_commit),
        .in_wait_o   (w_in_wait)
    );

    // Register-bank next values: flush > stall > capture/bubble
    always_comb begin
        w_valid_d  = r_valid_q;
        w_result_d = r_result_q;
        w_rtdata_d = r_rtdata_q;
        w_zero_d   = r_zero_q;
        w_rdaddr_d = r_rdaddr_q;
        w_ctrl_d   = r_ctrl_q;
        if (flush_i || (!stall_i && !w_capture)) begin
            w_valid_d  = 1'b0;
            w_result_d = '0;
            w_rtdata_d = '0;
            w_zero_d   = 1'b0;
            w_rdaddr_d = '0;
            w_ctrl_d   = CTRL_BUBBLE;
        end else if (!stall_i) begin
            w_valid_d  = valid_i;
            w_result_d = ALUResult_i;
            w_rtdata_d = RTdata_i;
            w_zero_d   = Zero_i;
            w_rdaddr_d = RDaddr_i;
            w_ctrl_d   = '{reg_write: RegWrite_i, mem_read: MemRead_i,
                           mem_write: MemWrite_i, mem_to_reg: MemtoReg_i};
        end
    end

    // EX/MEM register bank
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q  <= 1'b0;
            r_result_q <= '0;
            r_rtdata_q <= '0;
            r_zero_q   <= 1'b0;
            r_rdaddr_q <= '0;
            r_ctrl_q   <= CTRL_BUBBLE;
        end else begin
            r_valid_q  <= w_valid_d;
            r_result_q <= w_result_d;
            r_rtdata_q <= w_rtdata_d;
            r_zero_q   <= w_zero_d;
            r_rdaddr_q <= w_rdaddr_d;
            r_ctrl_q   <= w_ctrl_d;
        end
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] r_perf_q, w_perf_d;

    // Saturating count of stall cycles owed to MUL alone
    always_comb begin
        w_perf_d = r_perf_q;
        if (w_mul_busy && !stall_i && !flush_i && (r_perf_q != 32'hFFFF_FFFF)) begin
            w_perf_d = r_perf_q + 32'd1;
        end
    end

    // Performance counter register; flush does not clear it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_q <= '0;
        end else begin
            r_perf_q <= w_perf_d;
        end
    end

    assign perf_stall_o = r_perf_q;
`endif

    assign valid_o     = r_valid_q;
    assign ALUResult_o = r_result_q;
    assign RTdata_o    = r_rtdata_q;
    assign Zero_o      = r_zero_q;
    assign RDaddr_o    = r_rdaddr_q;
    assign RegWrite_o  = r_ctrl_q.reg_write;
    assign MemRead_o   = r_ctrl_q.mem_read;
    assign MemWrite_o  = r_ctrl_q.mem_write;
    assign MemtoReg_o  = r_ctrl_q.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_pipe
//  Brief    : Self-checking bench for ex_mem_pipe: directed scenarios then
//             random traffic against a cycle-occupancy reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe;

    localparam int LAT = 3;
    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                           OP_SUB = 3'b110, OP_MUL = 3'b011;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, Zero_i, stall_i, flush_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] ALUResult_i, RTdata_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
    logic        valid_o, Zero_o, ex_stall_o;
    logic [31:0] ALUResult_o, RTdata_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: how many EX cycles the current MUL has used so far
    // (0 = no MUL in flight) plus the expected EX/MEM contents
    int          spent = 0;
    bit          known = 0;
    logic [74:0] exp_vec = '0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(32), .REG_AW(5), .MUL_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
        .ALUResult_i(ALUResult_i), .Zero_i(Zero_i), .RTdata_i(RTdata_i),
        .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_o(valid_o), .ALUResult_o(ALUResult_o),
        .RTdata_o(RTdata_o), .Zero_o(Zero_o), .RDaddr_o(RDaddr_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .ex_stall_o(ex_stall_o)
    );

    wire [74:0] obs_vec = {valid_o, ALUResult_o, RTdata_o, Zero_o, RDaddr_o,
                           RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o};

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        logic mul_cause;
        if (spent == 0) mul_cause = valid_i && (ALUCtrl_i == OP_MUL) && (LAT > 1);
        else            mul_cause = (spent < LAT - 1);
        return stall_i | (~flush_i & mul_cause);
    endfunction

    function automatic logic [74:0] inputs_vec();
        return {valid_i, ALUResult_i, RTdata_i, Zero_i, RDaddr_i,
                RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i};
    endfunction

    task automatic model_edge();
        if (rst_i) begin
            exp_vec = '0; spent = 0; known = 1;
        end else if (flush_i) begin
            exp_vec = '0; spent = 0;
        end else if (stall_i) begin
            // everything holds
        end else if (spent > 0) begin
            if (spent == LAT - 1) begin
                exp_vec = inputs_vec(); spent = 0;
            end else begin
                exp_vec = '0; spent++;
            end
        end else if (!valid_i) begin
            exp_vec = '0;
        end else if (ALUCtrl_i == OP_MUL && LAT > 1) begin
            exp_vec = '0; spent = 1;
        end else begin
            exp_vec = inputs_vec();
        end
    endtask

    // One clock: check ex_stall_o mid-cycle, clock, check registers
    task automatic cycle(input string tag);
        #1;
        if (known) chk({tag, " ex_stall"}, {74'd0, ex_stall_o}, {74'd0, model_stall()});
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, " regs"}, obs_vec, exp_vec);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst_i = 0; valid_i = 0; ALUCtrl_i = OP_ADD; ALUResult_i = '0; RTdata_i = '0;
        Zero_i = 0; RDaddr_i = '0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0;
        MemtoReg_i = 0; stall_i = 0; flush_i = 0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] res, input logic [4:0] rd);
        valid_i = 1; ALUCtrl_i = op; ALUResult_i = res; RDaddr_i = rd; RegWrite_i = 1;
    endtask

    initial begin
        logic [2:0] ops [5];
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB; ops[4] = OP_MUL;
        idle_inputs();
        @(negedge clk);

        // Reset with live-looking inputs
        rst_i = 1; valid_i = 1; ALUResult_i = 32'hDEAD_BEEF;
        cycle("reset0");
        cycle("reset1");
        chk("reset valid_o", {74'd0, valid_o}, 75'd0);

        // Single-cycle ADD
        idle_inputs(); set_op(OP_ADD, 32'h7, 5'd5);
        cycle("add");
        chk("add result", {43'd0, ALUResult_o}, {43'd0, 32'h7});
        chk("add rd/wr", {69'd0, RDaddr_o, RegWrite_o}, {69'd0, 5'd5, 1'b1});
        idle_inputs(); cycle("idle0");

        // MUL: two stall cycles, commit at edge ending cycle 2
        set_op(OP_MUL, 32'h30, 5'd3);
        cycle("mul c0"); cycle("mul c1"); cycle("mul c2");
        chk("mul commit", {42'd0, valid_o, ALUResult_o}, {42'd0, 1'b1, 32'h30});
        idle_inputs(); cycle("idle1");

        // MUL with MEM stall in cycle 1
        set_op(OP_MUL, 32'h31, 5'd4);
        cycle("mstall c0");
        stall_i = 1; cycle("mstall c1");
        stall_i = 0; cycle("mstall c2");
        chk("mstall not yet", {74'd0, valid_o}, 75'd0);
        cycle("mstall c3");
        chk("mstall commit", {42'd0, valid_o, ALUResult_o}, {42'd0, 1'b1, 32'h31});
        idle_inputs(); cycle("idle2");

        // MUL flushed in cycle 1
        set_op(OP_MUL, 32'h32, 5'd6);
        cycle("mflush c0");
        flush_i = 1; cycle("mflush c1");
        idle_inputs(); cycle("mflush c2");

        // Stall and flush together over a valid ADD in EX/MEM
        set_op(OP_ADD, 32'h99, 5'd7); cycle("sf load");
        stall_i = 1; flush_i = 1; cycle("sf both");
        chk("sf bubble", {73'd0, valid_o, RegWrite_o}, 75'd0);
        idle_inputs(); cycle("idle3");

        // Back-to-back MULs
        set_op(OP_MUL, 32'h40, 5'd8);
        for (int i = 0; i < 7; i++) cycle("b2b mul");
        idle_inputs(); cycle("idle4");

        // Random traffic; EX inputs held while a MUL is in flight
        for (int i = 0; i < 600; i++) begin
            rst_i   = ($urandom % 60) == 0;
            stall_i = ($urandom % 5) == 0;
            flush_i = ($urandom % 9) == 0;
            if (spent == 0) begin
                valid_i     = ($urandom % 4) != 0;
                ALUCtrl_i   = ops[$urandom % 5];
                if (($urandom % 3) == 0) ALUCtrl_i = OP_MUL;
                ALUResult_i = $urandom; RTdata_i = $urandom; Zero_i = $urandom % 2;
                RDaddr_i    = 5'($urandom % 32);
                {RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i} = 4'($urandom % 16);
            end
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
